// File: rtl/load_store_queue.sv
`default_nettype none
// ============================================================================
// Module      : load_store_queue
// Description : In-order load/store buffer in front of the Tomasulo memory
//               unit. Holds memory instructions until their address and
//               store-data operands are resolved (snooping the CDB), then
//               dispatches them one per cycle, in program order, as a
//               one-cycle key_mem pulse carrying a 43-bit instruction word.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   flush           synchronous clear of every entry (mis-speculation)
//   issue_valid     issue stage presents an entry
//   issue_ready     queue can accept (count < DEPTH)
//   issue_store     1 = store, 0 = load
//   issue_tag       station tag returned with load results
//   issue_reg       load destination register
//   issue_addr_rdy  address operand is a value, else a pending tag in [2:0]
//   issue_addr      address value or producer tag
//   issue_data_rdy  store-data operand is a value (ignored for loads)
//   issue_data      store data value or producer tag
//   cdb_valid       CDB broadcast this cycle
//   cdb_tag         producer tag on the CDB
//   cdb_value       broadcast value
//   key_mem         registered one-cycle dispatch strobe
//   instruction     registered dispatch word (zero when key_mem is low)
//   count           number of occupied entries
// ============================================================================
module load_store_queue #(
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic                      issue_store,
  input  logic [2:0]                issue_tag,
  input  logic [3:0]                issue_reg,
  input  logic                      issue_addr_rdy,
  input  logic [15:0]               issue_addr,
  input  logic                      issue_data_rdy,
  input  logic [15:0]               issue_data,
  input  logic                      cdb_valid,
  input  logic [2:0]                cdb_tag,
  input  logic [15:0]               cdb_value,
  output logic                      key_mem,
  output logic [42:0]               instruction,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_store;
  logic [DEPTH-1:0] ent_addr_rdy;
  logic [DEPTH-1:0] ent_data_rdy;
  logic [2:0]       ent_tag  [DEPTH];
  logic [3:0]       ent_reg  [DEPTH];
  logic [15:0]      ent_addr [DEPTH];
  logic [15:0]      ent_data [DEPTH];

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  logic        do_push;
  logic        do_pop;
  logic [42:0] head_word;

  // issue_ready comes only from registered count; a same-cycle pop does not
  // open a slot for a push into a full queue.
  assign issue_ready = (count < CNT_W'(DEPTH));
  assign do_push     = issue_valid && issue_ready;

  // Dispatch looks at head operand state as registered at the previous edge,
  // so a CDB match on the head becomes usable one cycle later.
  assign do_pop = (count != '0) && ent_addr_rdy[head] && ent_data_rdy[head];

  // Dispatch word: {tag, 1, store, 2'b00, reg, hi16, lo16}.
  // Stores carry address in the high half and data in the low half; loads
  // carry zero in the high half and the address in the low half.
  always_comb begin
    head_word = {ent_tag[head], 1'b1, ent_store[head], 2'b00, ent_reg[head],
                 (ent_store[head] ? ent_addr[head] : 16'h0000),
                 (ent_store[head] ? ent_data[head] : ent_addr[head])};
  end

  // --------------------------------------------------------------------------
  // Incoming entry, with same-cycle CDB bypass on pending operands
  // --------------------------------------------------------------------------
  logic        push_addr_hit;
  logic        push_data_hit;
  logic        push_addr_rdy;
  logic        push_data_rdy;
  logic [15:0] push_addr;
  logic [15:0] push_data;

  always_comb begin
    push_addr_hit = cdb_valid && !issue_addr_rdy && (issue_addr[2:0] == cdb_tag);
    // Loads have no data operand, so their data field never waits.
    push_data_hit = cdb_valid && issue_store && !issue_data_rdy &&
                    (issue_data[2:0] == cdb_tag);
    push_addr_rdy = issue_addr_rdy || push_addr_hit;
    push_data_rdy = !issue_store || issue_data_rdy || push_data_hit;
    push_addr     = push_addr_hit ? cdb_value : issue_addr;
    push_data     = push_data_hit ? cdb_value : issue_data;
  end

  // --------------------------------------------------------------------------
  // Per-entry CDB snoop hits
  // --------------------------------------------------------------------------
  logic [DEPTH-1:0] addr_hit;
  logic [DEPTH-1:0] data_hit;

  always_comb begin
    addr_hit = '0;
    data_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_hit[i] = cdb_valid && ent_valid[i] && !ent_addr_rdy[i] &&
                    (ent_addr[i][2:0] == cdb_tag);
      data_hit[i] = cdb_valid && ent_valid[i] && !ent_data_rdy[i] &&
                    (ent_data[i][2:0] == cdb_tag);
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy update
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointers, count and dispatch outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      key_mem     <= 1'b0;
      instruction <= '0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      key_mem     <= 1'b0;
      instruction <= '0;
    end else begin
      count <= count_next;
      if (do_push) begin
        tail <= tail + PTR_W'(1);
      end
      if (do_pop) begin
        head        <= head + PTR_W'(1);
        key_mem     <= 1'b1;
        instruction <= head_word;
      end else begin
        key_mem     <= 1'b0;
        instruction <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Entry array: push write, pop invalidate, CDB snoop
  // --------------------------------------------------------------------------
  // While count < DEPTH and count != 0 head and tail differ, and when the
  // queue is empty there is no pop, so the push slot never collides with the
  // popped slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_valid    <= '0;
      ent_store    <= '0;
      ent_addr_rdy <= '0;
      ent_data_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_tag[i]  <= '0;
        ent_reg[i]  <= '0;
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else if (flush) begin
      ent_valid    <= '0;
      ent_addr_rdy <= '0;
      ent_data_rdy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && (PTR_W'(i) == tail)) begin
          ent_valid[i]    <= 1'b1;
          ent_store[i]    <= issue_store;
          ent_tag[i]      <= issue_tag;
          ent_reg[i]      <= issue_reg;
          ent_addr_rdy[i] <= push_addr_rdy;
          ent_addr[i]     <= push_addr;
          ent_data_rdy[i] <= push_data_rdy;
          ent_data[i]     <= push_data;
        end else begin
          if (addr_hit[i]) begin
            ent_addr_rdy[i] <= 1'b1;
            ent_addr[i]     <= cdb_value;
          end
          if (data_hit[i]) begin
            ent_data_rdy[i] <= 1'b1;
            ent_data[i]     <= cdb_value;
          end
          if (do_pop && (PTR_W'(i) == head)) begin
            ent_valid[i]    <= 1'b0;
            ent_addr_rdy[i] <= 1'b0;
            ent_data_rdy[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
